seven_seg_mux: RTL and testbench

Time-multiplexed driver for the Basys 3 four-digit common-anode seven-segment display. It consumes the four 4-bit digit values produced by the mode/input-select stage (A = leftmost, D = rightmost). It scans one digit at a time with a programmable dwell and an anti-ghosting guard interval, and decodes each nibble to hexadecimal segment patterns. Inputs are snapshotted once per full scan so a mid-scan change never shows a torn value.

---
 rtl/seg7_pkg.sv | 33 +++
 rtl/hex_to_seg7.sv | 32 +++
 rtl/seven_seg_mux.sv | 100 ++++++++++
 tb/tb_seven_seg_mux.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment display driver.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Digit index doubles as the anode bit position (D is rightmost, an[0]).
  typedef enum logic [1:0] {
    DIG_D = 2'd0,
    DIG_C = 2'd1,
    DIG_B = 2'd2,
    DIG_A = 2'd3
  } digit_idx_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_mux.sv
// Four-digit multiplexed seven-segment driver with per-slot guard blanking.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seven_seg_mux
  import seg7_pkg::*;
#(
  parameter int DIGIT_TICKS = 100_000,
  parameter int GUARD_TICKS = 1_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] a_in,
  input  logic [3:0] b_in,
  input  logic [3:0] c_in,
  input  logic [3:0] d_in,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int TW = (DIGIT_TICKS > 2) ? $clog2(DIGIT_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIGIT_TICKS - 1);

  logic [TW-1:0]   tick_reg, tick_next;
  digit_idx_t      idx_reg, idx_next;
  logic [3:0][3:0] snap_reg, snap_next;
  logic [3:0][3:0] snap_eff;
  logic [6:0]      seg_reg, seg_next;
  logic [3:0]      an_reg, an_next;
  logic [3:0]      cur_nibble;
  logic [6:0]      cur_seg;
  logic            scan_start;
  logic            in_guard;
  logic            blank_lead;

  assign scan_start = (idx_reg == DIG_D) && (tick_reg == '0);
  assign in_guard   = int'(tick_reg) < GUARD_TICKS;

  // The first slot of a scan decodes the value being captured, so a zero-length
  // guard never shows a stale digit D.
  assign snap_eff   = scan_start ? {a_in, b_in, c_in, d_in} : snap_reg;
  assign snap_next  = snap_eff;
  assign cur_nibble = snap_eff[idx_reg];

  hex_to_seg7 u_dec (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

`ifdef SEG_LEADING_ZERO_BLANK_EN
  always_comb begin
    blank_lead = 1'b0;
    case (idx_reg)
      DIG_A:   blank_lead = (snap_eff[3] == 4'h0);
      DIG_B:   blank_lead = (snap_eff[3] == 4'h0) && (snap_eff[2] == 4'h0);
      DIG_C:   blank_lead = (snap_eff[3] == 4'h0) && (snap_eff[2] == 4'h0) &&
                            (snap_eff[1] == 4'h0);
      default: blank_lead = 1'b0;
    endcase
  end
`else
  assign blank_lead = 1'b0;
`endif

  always_comb begin
    tick_next = tick_reg + 1'b1;
    idx_next  = idx_reg;
    if (tick_reg == TICK_LAST) begin
      tick_next = '0;
      idx_next  = digit_idx_t'(idx_reg + 2'd1);
    end

    an_next  = AN_OFF;
    seg_next = SEG_BLANK;
    if (!in_guard) begin
      an_next  = ~(4'b0001 << idx_reg);
      seg_next = blank_lead ? SEG_BLANK : cur_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tick_reg <= '0;
      idx_reg  <= DIG_D;
      snap_reg <= '0;
      an_reg   <= AN_OFF;
      seg_reg  <= SEG_BLANK;
    end else begin
      tick_reg <= tick_next;
      idx_reg  <= idx_next;
      snap_reg <= snap_next;
      an_reg   <= an_next;
      seg_reg  <= seg_next;
    end
  end

  assign seg = seg_reg;
  assign an  = an_reg;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_seven_seg_mux.sv
// Randomized self-checking bench for seven_seg_mux against a cycle-count model.
module tb_seven_seg_mux;

  localparam int DT = 8;
  localparam int GT = 2;
  localparam int SCAN = 4 * DT;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] a_in = '0, b_in = '0, c_in = '0, d_in = '0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int checks = 0;
  int errors = 0;

  // Model state: cycles elapsed since reset release, plus the captured digits.
  int         n_cyc = 0;
  logic [3:0] snap [4];
  logic [6:0] hex_tab [16];
  logic [6:0] exp_seg;
  logic [3:0] exp_an;

  always #5 clk = ~clk;

  seven_seg_mux #(.DIGIT_TICKS(DT), .GUARD_TICKS(GT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .a_in    (a_in),
    .b_in    (b_in),
    .c_in    (c_in),
    .d_in    (d_in),
    .seg     (seg),
    .an      (an),
    .dp      (dp)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n_cyc);
    end
  endtask

  // One clock: predict from elapsed time, then compare after the edge.
  task automatic step();
    int t, slot;
    bit blank;
    @(posedge clk);
    if (!reset_n) begin
      n_cyc = 0;
      for (int i = 0; i < 4; i++) snap[i] = 4'h0;
      exp_an  = 4'hF;
      exp_seg = 7'h7F;
    end else begin
      if (n_cyc % SCAN == 0) begin
        snap[0] = d_in; snap[1] = c_in; snap[2] = b_in; snap[3] = a_in;
      end
      t    = n_cyc % DT;
      slot = (n_cyc / DT) % 4;
      if (t < GT) begin
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
      end else begin
        exp_an = 4'hF;
        exp_an[slot] = 1'b0;
        blank = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (slot > 0) begin
          blank = 1'b1;
          for (int k = slot; k < 4; k++) if (snap[k] != 4'h0) blank = 1'b0;
        end
`endif
        exp_seg = blank ? 7'h7F : hex_tab[snap[slot]];
      end
      n_cyc++;
    end
    #1;
    chk("an", 32'(an), 32'(exp_an));
    chk("seg", 32'(seg), 32'(exp_seg));
    chk("dp", 32'(dp), 32'd1);
  endtask

  initial begin
    hex_tab[0]  = 7'h40; hex_tab[1]  = 7'h79; hex_tab[2]  = 7'h24; hex_tab[3]  = 7'h30;
    hex_tab[4]  = 7'h19; hex_tab[5]  = 7'h12; hex_tab[6]  = 7'h02; hex_tab[7]  = 7'h78;
    hex_tab[8]  = 7'h00; hex_tab[9]  = 7'h10; hex_tab[10] = 7'h08; hex_tab[11] = 7'h03;
    hex_tab[12] = 7'h46; hex_tab[13] = 7'h21; hex_tab[14] = 7'h06; hex_tab[15] = 7'h0E;
    for (int i = 0; i < 4; i++) snap[i] = 4'h0;

    // Reset held with live inputs
    a_in = 4'h1; b_in = 4'h9; c_in = 4'h9; d_in = 4'h4;
    for (int i = 0; i < 5; i++) step();
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) step();
    chk("guard_after_reset", 32'(an), 32'hF);
    step();
    chk("first_lit_d", 32'(an), 32'hE);
    chk("first_lit_seg", 32'(seg), 32'h19);

    // Scan order with fixed digits, then a digit D change mid-scan
    while (n_cyc != SCAN + 2 * DT) step();
    d_in = 4'hF;
    for (int i = 0; i < 2 * SCAN; i++) step();

    // Mid-scan reset at slot B, tick 5
    a_in = 4'h3; b_in = 4'hC; c_in = 4'h5; d_in = 4'hA;
    while (n_cyc % SCAN != 2 * DT + 5) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < SCAN + 4; i++) step();

    // Leading zeros
    a_in = 4'h0; b_in = 4'h0; c_in = 4'h0; d_in = 4'h7;
    while (n_cyc % SCAN != 0) step();
    for (int i = 0; i < 2 * SCAN; i++) step();
    a_in = 4'h0; b_in = 4'h0; c_in = 4'h2; d_in = 4'h0;
    for (int i = 0; i < SCAN; i++) step();

    // Hex sweep on digit D
    for (int v = 0; v < 16; v++) begin
      d_in = 4'(v);
      for (int i = 0; i < SCAN; i++) step();
    end

    // Random inputs changing at arbitrary cycles, with occasional resets
    for (int i = 0; i < 40 * SCAN; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        a_in = 4'($urandom_range(0, 15));
        b_in = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
        c_in = 4'($urandom_range(0, 15));
        d_in = 4'($urandom_range(0, 15));
      end
      reset_n = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
